// File: rtl/mips_multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared state, opcode and control-word definitions for the
//             multicycle MIPS main control FSM and ALU control.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SL2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       ir_write;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_multicycle_ctrl_if
//  Purpose  : Opcode/memory handshake and datapath control bundle between the
//             main control FSM (master) and the multicycle datapath (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface mips_multicycle_ctrl_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, branch, ir_write, mem_write, iord, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, branch, ir_write, mem_write, iord, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal_op
    );

endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_decode
//  Purpose  : Pure state -> control-word lookup for the multicycle MIPS FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_IDLE;
        case (i_state)
            // PC+4 is computed here; the top gates pc_write/ir_write with mem_ready.
            S_FETCH: begin
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_b = SRC_B_FOUR;
                o_ctrl.alu_op    = ALU_OP_ADD;
                o_ctrl.pc_src    = PC_SRC_ALU;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRC_B_IMM_SL2;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_REG;
                o_ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_REG;
                o_ctrl.alu_op    = ALU_OP_SUB;
                o_ctrl.pc_src    = PC_SRC_ALUOUT;
                o_ctrl.branch    = 1'b1;
            end
            S_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_src   = PC_SRC_JUMP;
                o_ctrl.pc_write = 1'b1;
            end
            default: o_ctrl = CTRL_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_multicycle_ctrl
//  Purpose  : Main control FSM of the multicycle MIPS core (state register,
//             next-state logic, mem_ready and reset gating of the control word).
//  Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    mips_multicycle_ctrl_if.master bus,
    output logic [3:0]             state_o
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    ctrl_t  w_gated;
    logic   w_illegal;

    mips_ctrl_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // Everything is forced low while rst_n is asserted so no write survives reset.
    always_comb begin
        w_gated = CTRL_IDLE;
        if (rst_n) begin
            w_gated = w_ctrl;
            if (r_state == S_FETCH) begin
                w_gated.pc_write = bus.mem_ready;
                w_gated.ir_write = bus.mem_ready;
            end
        end
    end

    assign w_illegal = rst_n && (r_state == S_DECODE) && !is_legal_op(bus.opcode);

    assign bus.pc_write   = w_gated.pc_write;
    assign bus.branch     = w_gated.branch;
    assign bus.ir_write   = w_gated.ir_write;
    assign bus.mem_write  = w_gated.mem_write;
    assign bus.iord       = w_gated.iord;
    assign bus.reg_write  = w_gated.reg_write;
    assign bus.reg_dst    = w_gated.reg_dst;
    assign bus.mem_to_reg = w_gated.mem_to_reg;
    assign bus.alu_src_a  = w_gated.alu_src_a;
    assign bus.alu_src_b  = w_gated.alu_src_b;
    assign bus.alu_op     = w_gated.alu_op;
    assign bus.pc_src     = w_gated.pc_src;
    assign bus.illegal_op = w_illegal;
    assign state_o        = r_state;

endmodule
`default_nettype wire
